// File: rtl/adam_periph_uart_rx.sv
// UART receiver: oversampled start/data/parity/stop framing with a per-bit clock divider,
// LSB-aligned valid/ready output, one-cycle error pulses and a pause request/acknowledge handshake.
module adam_periph_uart_rx #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pause_req,
  output logic                  pause_ack,
  input  logic                  parity_select,
  input  logic                  parity_control,
  input  logic [3:0]            data_length,
  input  logic [1:0]            stop_bits,
  input  logic [DATA_WIDTH-1:0] baud_rate,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] mst_data,
  output logic                  mst_valid,
  input  logic                  mst_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd6;
  localparam logic [2:0] ST_PAUSED    = 3'd7;

  // Input synchronizer plus one history flop for start-edge detection.
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q,   cnt_d;

  // Frame configuration captured at the start edge.
  logic [DATA_WIDTH-1:0] baud_q,     baud_d;
  logic [3:0]            len_q,      len_d;
  logic                  par_ctrl_q, par_ctrl_d;
  logic                  par_sel_q,  par_sel_d;
  logic [1:0]            stop_q,     stop_d;

  logic [3:0]  bit_q,      bit_d;
  logic [1:0]  stop_cnt_q, stop_cnt_d;
  logic [14:0] shift_q,    shift_d;
  logic        par_acc_q,  par_acc_d;
  logic        par_bad_q,  par_bad_d;
  logic        stop_bad_q, stop_bad_d;

  logic [DATA_WIDTH-1:0] mst_data_q, mst_data_d;
  logic                  mst_valid_q, mst_valid_d;
  logic                  pause_ack_q, pause_ack_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_err_q, overrun_err_d;

  logic                  rxs;
  logic                  enabled;
  logic                  start_edge;
  logic [DATA_WIDTH-1:0] limit;
  logic                  sample;

  assign rxs        = sync2_q;
  assign enabled    = (data_length != 4'd0) && (baud_rate >= DATA_WIDTH'(2));
  assign start_edge = prev_q && !rxs;
  // The start bit is checked half a bit after the edge so later samples land mid-bit.
  assign limit      = (state_q == ST_START) ? (baud_q >> 1) : baud_q;
  assign sample     = (cnt_q == limit - DATA_WIDTH'(1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    sync1_d       = rx;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;
    state_d       = state_q;
    cnt_d         = cnt_q + DATA_WIDTH'(1);
    baud_d        = baud_q;
    len_d         = len_q;
    par_ctrl_d    = par_ctrl_q;
    par_sel_d     = par_sel_q;
    stop_d        = stop_q;
    bit_d         = bit_q;
    stop_cnt_d    = stop_cnt_q;
    shift_d       = shift_q;
    par_acc_d     = par_acc_q;
    par_bad_d     = par_bad_q;
    stop_bad_d    = stop_bad_q;
    mst_data_d    = mst_data_q;
    mst_valid_d   = mst_valid_q;
    pause_ack_d   = pause_ack_q;
    parity_err_d  = 1'b0;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;

    if (mst_valid_q && mst_ready) begin
      mst_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pause_req) begin
          state_d     = ST_PAUSED;
          pause_ack_d = 1'b1;
        end else if (enabled && start_edge) begin
          state_d    = ST_START;
          baud_d     = baud_rate;
          len_d      = data_length;
          par_ctrl_d = parity_control;
          par_sel_d  = parity_select;
          stop_d     = stop_bits;
          bit_d      = 4'd0;
          stop_cnt_d = 2'd0;
          shift_d    = '0;
          par_acc_d  = 1'b0;
          par_bad_d  = 1'b0;
          stop_bad_d = 1'b0;
        end
      end

      ST_START: begin
        if (sample) begin
          cnt_d   = '0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (sample) begin
          cnt_d          = '0;
          shift_d[bit_q] = rxs;
          par_acc_d      = par_acc_q ^ rxs;
          bit_d          = bit_q + 4'd1;
          if (bit_q == len_q - 4'd1) begin
            state_d = par_ctrl_q ? ST_PARITY : ST_STOP;
          end
        end
      end

      ST_PARITY: begin
        if (sample) begin
          cnt_d     = '0;
          par_bad_d = (rxs != (par_acc_q ^ par_sel_q));
          state_d   = ST_STOP;
        end
      end

      ST_STOP: begin
        if (sample) begin
          cnt_d      = '0;
          stop_bad_d = stop_bad_q | !rxs;
          stop_cnt_d = stop_cnt_q + 2'd1;
          if (stop_cnt_q == stop_q) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // A framing error masks any parity result for the same character.
        if (stop_bad_q) begin
          frame_err_d = 1'b1;
          state_d     = ST_WAIT_IDLE;
        end else if (par_bad_q) begin
          parity_err_d = 1'b1;
          state_d      = ST_IDLE;
        end else if (mst_valid_q && !mst_ready) begin
          overrun_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          mst_data_d  = DATA_WIDTH'(shift_q);
          mst_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      ST_WAIT_IDLE: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end

      ST_PAUSED: begin
        if (!pause_req) begin
          state_d     = ST_IDLE;
          pause_ack_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      baud_q        <= '0;
      len_q         <= 4'd0;
      par_ctrl_q    <= 1'b0;
      par_sel_q     <= 1'b0;
      stop_q        <= 2'd0;
      bit_q         <= 4'd0;
      stop_cnt_q    <= 2'd0;
      shift_q       <= '0;
      par_acc_q     <= 1'b0;
      par_bad_q     <= 1'b0;
      stop_bad_q    <= 1'b0;
      mst_data_q    <= '0;
      mst_valid_q   <= 1'b0;
      pause_ack_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      baud_q        <= baud_d;
      len_q         <= len_d;
      par_ctrl_q    <= par_ctrl_d;
      par_sel_q     <= par_sel_d;
      stop_q        <= stop_d;
      bit_q         <= bit_d;
      stop_cnt_q    <= stop_cnt_d;
      shift_q       <= shift_d;
      par_acc_q     <= par_acc_d;
      par_bad_q     <= par_bad_d;
      stop_bad_q    <= stop_bad_d;
      mst_data_q    <= mst_data_d;
      mst_valid_q   <= mst_valid_d;
      pause_ack_q   <= pause_ack_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign mst_data    = mst_data_q;
  assign mst_valid   = mst_valid_q;
  assign pause_ack   = pause_ack_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_adam_periph_uart_rx.sv
// Directed and randomized frames for adam_periph_uart_rx, scored against a frame-level model
// (expected words and error-pulse counts derived from the bits each frame puts on the line).
module tb_adam_periph_uart_rx;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          pause_req;
  logic          pause_ack;
  logic          parity_select;
  logic          parity_control;
  logic [3:0]    data_length;
  logic [1:0]    stop_bits;
  logic [DW-1:0] baud_rate;
  logic          rx;
  logic [DW-1:0] mst_data;
  logic          mst_valid;
  logic          mst_ready;
  logic          parity_err;
  logic          frame_err;
  logic          overrun_err;

  always #10 clk = ~clk;

  adam_periph_uart_rx #(.DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .pause_req      (pause_req),
    .pause_ack      (pause_ack),
    .parity_select  (parity_select),
    .parity_control (parity_control),
    .data_length    (data_length),
    .stop_bits      (stop_bits),
    .baud_rate      (baud_rate),
    .rx             (rx),
    .mst_data       (mst_data),
    .mst_valid      (mst_valid),
    .mst_ready      (mst_ready),
    .parity_err     (parity_err),
    .frame_err      (frame_err),
    .overrun_err    (overrun_err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: collects handshaked words and error pulses, and checks held data stays put.
  logic [DW-1:0] got_q[$];
  int            n_par = 0, n_frm = 0, n_ovr = 0;
  logic          prev_hold = 1'b0;
  logic          prev_valid = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            valid_rise_cyc = -1;

  always @(negedge clk) begin
    if (rst) begin
      if (mst_valid && mst_ready) got_q.push_back(mst_data);
      if (parity_err)  n_par++;
      if (frame_err)   n_frm++;
      if (overrun_err) n_ovr++;
      if (prev_hold) check("held_data_stable", mst_data, prev_data);
      if (mst_valid && !prev_valid) valid_rise_cyc = cyc;
    end
    prev_hold  = mst_valid && !mst_ready && rst;
    prev_data  = mst_data;
    prev_valid = mst_valid;
  end

  // Model state: expected words and pulse totals.
  logic [DW-1:0] exp_q[$];
  int            exp_par = 0, exp_frm = 0, exp_ovr = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one character on rx; low_stop selects a stop bit to drive low (-1 for none).
  task automatic send_frame(input logic [14:0] data, input int len, input bit par_on,
                            input bit par_sel, input bit par_flip, input int nstop,
                            input int low_stop, input int baud);
    logic p;
    p  = par_sel;
    rx = 1'b0;
    tick(baud);
    for (int i = 0; i < len; i++) begin
      rx = data[i];
      p  = p ^ data[i];
      tick(baud);
    end
    if (par_on) begin
      rx = p ^ par_flip;
      tick(baud);
    end
    for (int s = 0; s < nstop; s++) begin
      rx = (s == low_stop) ? 1'b0 : 1'b1;
      tick(baud);
    end
    rx = 1'b1;
  endtask

  // Frame-level outcome with mst_ready held high: framing beats parity beats a delivered word.
  task automatic expect_frame(input logic [14:0] data, input int len, input bit par_on,
                              input bit par_flip, input int nstop, input int low_stop);
    logic [DW-1:0] w;
    w = 0;
    for (int i = 0; i < len; i++) w[i] = data[i];
    if (low_stop >= 0 && low_stop < nstop) exp_frm++;
    else if (par_on && par_flip) exp_par++;
    else exp_q.push_back(w);
  endtask

  task automatic compare(input string tag);
    logic [DW-1:0] g, e;
    check({tag, "_word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_word"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_parity_pulses"},  32'(n_par), 32'(exp_par));
    check({tag, "_frame_pulses"},   32'(n_frm), 32'(exp_frm));
    check({tag, "_overrun_pulses"}, 32'(n_ovr), 32'(exp_ovr));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(mst_valid),   32'(0));
    check({tag, "_data"},    mst_data,         32'(0));
    check({tag, "_ack"},     32'(pause_ack),   32'(0));
    check({tag, "_perr"},    32'(parity_err),  32'(0));
    check({tag, "_ferr"},    32'(frame_err),   32'(0));
    check({tag, "_oerr"},    32'(overrun_err), 32'(0));
  endtask

  initial begin
    int t;
    int ack_cyc;
    int len, sb, b, low;
    bit pon, sel, flip;
    logic [14:0] d;

    rst            = 1'b0;
    rx             = 1'b1;
    pause_req      = 1'b0;
    parity_select  = 1'b0;
    parity_control = 1'b1;
    data_length    = 4'd8;
    stop_bits      = 2'd1;
    baud_rate      = 32'd8;
    mst_ready      = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst = 1'b1;
    tick(5);

    // Every 8-bit value, even parity, two stop bits.
    for (int c = 0; c < 256; c++) begin
      send_frame(15'(c), 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
      expect_frame(15'(c), 8, 1'b1, 1'b0, 2, -1);
      tick(2);
    end
    tick(40);
    compare("stream");

    // Real 115200 Bd divider, a full frame and then a short low glitch.
    baud_rate = 32'd434;
    tick(2);
    send_frame(15'h0C3, 8, 1'b1, 1'b0, 1'b0, 2, -1, 434);
    expect_frame(15'h0C3, 8, 1'b1, 1'b0, 2, -1);
    tick(434);
    rx = 1'b0;
    tick(100);
    rx = 1'b1;
    tick(600);
    compare("baud434_glitch");
    baud_rate = 32'd8;
    tick(2);

    // Parity error, then a clean character.
    send_frame(15'h0A5, 8, 1'b1, 1'b0, 1'b1, 2, -1, 8);
    expect_frame(15'h0A5, 8, 1'b1, 1'b1, 2, -1);
    tick(4);
    send_frame(15'h05A, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
    expect_frame(15'h05A, 8, 1'b1, 1'b0, 2, -1);
    tick(40);
    compare("parity");

    // Low first stop bit followed by a break of three bit times.
    send_frame(15'h03C, 8, 1'b1, 1'b0, 1'b0, 1, 0, 8);
    exp_frm++;
    rx = 1'b0;
    tick(24);
    rx = 1'b1;
    tick(16);
    send_frame(15'h05A, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
    expect_frame(15'h05A, 8, 1'b1, 1'b0, 2, -1);
    tick(40);
    compare("framing");

    // Overrun: first word held, the next two dropped.
    mst_ready = 1'b0;
    send_frame(15'h011, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
    tick(2);
    send_frame(15'h022, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
    tick(2);
    send_frame(15'h033, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
    exp_ovr += 2;
    tick(16);
    check("overrun_valid_held", 32'(mst_valid), 32'(1));
    check("overrun_data_held", mst_data, 32'h11);
    mst_ready = 1'b1;
    tick(4);
    check("overrun_valid_drops", 32'(mst_valid), 32'(0));
    exp_q.push_back(32'h11);
    compare("overrun");

    // Receiver disabled by data_length = 0 and by baud_rate < 2.
    data_length = 4'd0;
    tick(2);
    send_frame(15'h096, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
    tick(16);
    data_length = 4'd8;
    baud_rate   = 32'd1;
    tick(2);
    send_frame(15'h069, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
    tick(16);
    baud_rate = 32'd8;
    tick(2);
    send_frame(15'h081, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
    expect_frame(15'h081, 8, 1'b1, 1'b0, 2, -1);
    tick(40);
    compare("disabled");

    // Randomized configurations, data, parity flips and low stop bits.
    for (int k = 0; k < 40; k++) begin
      len  = $urandom_range(1, 15);
      pon  = 1'($urandom_range(0, 1));
      sel  = 1'($urandom_range(0, 1));
      sb   = $urandom_range(0, 3);
      b    = $urandom_range(8, 12);
      d    = 15'($urandom);
      flip = pon && ($urandom_range(0, 3) == 0);
      low  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, sb)) : -1;
      data_length    = 4'(len);
      parity_control = pon;
      parity_select  = sel;
      stop_bits      = 2'(sb);
      baud_rate      = 32'(b);
      tick(2);
      send_frame(d, len, pon, sel, flip, sb + 1, low, b);
      expect_frame(d, len, pon, flip, sb + 1, low);
      tick(2 * b);
    end
    tick(40);
    compare("random");
    data_length    = 4'd8;
    parity_control = 1'b1;
    parity_select  = 1'b0;
    stop_bits      = 2'd1;
    baud_rate      = 32'd8;
    tick(4);

    // Pause requested mid-frame: the frame completes first and its word stays held.
    mst_ready      = 1'b0;
    valid_rise_cyc = -1;
    fork
      send_frame(15'h077, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
      begin
        tick(4 * 8 + 3);
        pause_req = 1'b1;
      end
    join
    t = 0;
    while (!pause_ack && t < 200) begin
      tick(1);
      t++;
    end
    ack_cyc = cyc;
    check("pause_ack_seen", 32'(pause_ack), 32'(1));
    check("pause_word_before_ack", 32'(valid_rise_cyc >= 0 && valid_rise_cyc < ack_cyc), 32'(1));
    check("pause_word_data", mst_data, 32'h77);
    send_frame(15'h099, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
    tick(16);
    check("paused_ack_holds", 32'(pause_ack), 32'(1));
    check("paused_valid_holds", 32'(mst_valid), 32'(1));
    check("paused_data_holds", mst_data, 32'h77);
    pause_req = 1'b0;
    check("unpause_ack_same_cycle", 32'(pause_ack), 32'(1));
    tick(1);
    check("unpause_ack_next_cycle", 32'(pause_ack), 32'(0));
    mst_ready = 1'b1;
    tick(2);
    exp_q.push_back(32'h77);
    send_frame(15'h042, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
    expect_frame(15'h042, 8, 1'b1, 1'b0, 2, -1);
    tick(40);
    compare("pause");

    // Reset in the middle of a frame while an older word is held.
    mst_ready = 1'b0;
    send_frame(15'h024, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
    tick(16);
    check("pre_reset_valid", 32'(mst_valid), 32'(1));
    fork
      send_frame(15'h0C3, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
      begin
        tick(5 * 8);
        rst = 1'b0;
        tick(2);
        check_reset_outputs("midframe_reset");
      end
    join
    tick(4);
    rst       = 1'b1;
    mst_ready = 1'b1;
    tick(40);
    compare("reset_midframe");
    send_frame(15'h0E7, 8, 1'b1, 1'b0, 1'b0, 2, -1, 8);
    expect_frame(15'h0E7, 8, 1'b1, 1'b0, 2, -1);
    tick(40);
    compare("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
